// File: rtl/matdet_pkg.sv
// Shared types and constants for the permutation-expansion determinant engine.
package matdet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TERM,
        ST_STEP,
        ST_DONE
    } matdet_state_e;

    localparam int MATDET_DEF_W     = 8;
    localparam int MATDET_DEF_MAX_N = 5;
    localparam int MATDET_MIN_N     = 1;

    // Legal orders are MATDET_MIN_N..max_n; anything else is reported via err.
    function automatic logic matdet_size_ok(input logic [2:0] n, input int max_n);
        return (int'(n) >= MATDET_MIN_N) && (int'(n) <= max_n);
    endfunction

endpackage

// File: rtl/matdet_perm_gen.sv
// Heap's-algorithm permutation generator: one transposition per step strobe,
// parity flips on every step, identity with even parity after init.
module matdet_perm_gen
    import matdet_pkg::*;
#(
    parameter int MAX_N = MATDET_DEF_MAX_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_i,
    input  logic                 step_i,
    input  logic [2:0]           n_i,
    output logic [3*MAX_N-1:0]   perm_o,
    output logic                 neg_o,
    output logic                 last_o
);

    logic [2:0] perm_q [MAX_N];
    logic [2:0] perm_d [MAX_N];
    logic [2:0] c_q    [MAX_N];
    logic [2:0] c_d    [MAX_N];
    logic       neg_q, neg_d;
    logic       found;
    logic [2:0] sel;
    logic [2:0] partner;

    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        // Descending scan so the final hit is the smallest qualifying index.
        for (int i = MAX_N - 1; i >= 1; i--) begin
            if ((3'(i) < n_i) && (c_q[i] < 3'(i))) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
        partner = sel[0] ? c_q[sel] : 3'd0;

        perm_d = perm_q;
        c_d    = c_q;
        neg_d  = neg_q;
        if (init_i) begin
            for (int i = 0; i < MAX_N; i++) begin
                perm_d[i] = 3'(i);
                c_d[i]    = 3'd0;
            end
            neg_d = 1'b0;
        end else if (step_i && found) begin
            perm_d[sel]     = perm_q[partner];
            perm_d[partner] = perm_q[sel];
            for (int j = 0; j < MAX_N; j++) begin
                if (3'(j) < sel) begin
                    c_d[j] = 3'd0;
                end
            end
            c_d[sel] = c_q[sel] + 3'd1;
            neg_d    = ~neg_q;
        end
        last_o = ~found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_N; i++) begin
                perm_q[i] <= 3'd0;
                c_q[i]    <= 3'd0;
            end
            neg_q <= 1'b0;
        end else begin
            perm_q <= perm_d;
            c_q    <= c_d;
            neg_q  <= neg_d;
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_N; gi++) begin : g_perm_out
            assign perm_o[3*gi +: 3] = perm_q[gi];
        end
    endgenerate

    assign neg_o = neg_q;

endmodule

// File: rtl/matrix_determ_nxn.sv
// Exact NxN determinant by signed sum over all permutations, one multiply per
// cycle; results are registered and held while start stays high.
module matrix_determ_nxn
    import matdet_pkg::*;
#(
    parameter int W     = MATDET_DEF_W,
    parameter int MAX_N = MATDET_DEF_MAX_N,
    parameter int ACC_W = MAX_N*W + 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               size,
    input  logic [MAX_N*MAX_N*W-1:0] matrix,
    output logic                     done,
    output logic [W-1:0]             determinant,
    output logic [ACC_W-1:0]         det_full,
    output logic                     overflow,
    output logic                     err
);

    localparam int NE = MAX_N * MAX_N;
    localparam int IW = $clog2(NE);
    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((64'sd1 <<< (W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;

    matdet_state_e state_q, state_d;

    logic signed [W-1:0]     elem_in [NE];
    logic signed [W-1:0]     mat_q   [NE];
    logic [2:0]              n_q, n_d;
    logic [2:0]              r_q, r_d;
    logic                    bad_q, bad_d;
    logic signed [ACC_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] det_q, det_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;

    logic [3*MAX_N-1:0]      perm_flat;
    logic [2:0]              perm_a [MAX_N];
    logic                    pg_init, pg_step, pg_neg, pg_last;
    logic [2:0]              col;
    logic [IW-1:0]           flat_idx;
    logic signed [W-1:0]     elem;
    logic signed [ACC_W+W-1:0] mult;

    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_mat
            assign elem_in[gi] = matrix[gi*W +: W];
            always_ff @(posedge clk) begin
                if (state_q == ST_LOAD) begin
                    mat_q[gi] <= elem_in[gi];
                end
            end
        end
        for (genvar gi = 0; gi < MAX_N; gi++) begin : g_perm
            assign perm_a[gi] = perm_flat[3*gi +: 3];
        end
    endgenerate

    assign pg_init = (state_q == ST_LOAD);
    assign pg_step = (state_q == ST_STEP) && start && !pg_last;

    matdet_perm_gen #(.MAX_N(MAX_N)) u_perm (
        .clk    (clk),
        .rst    (rst),
        .init_i (pg_init),
        .step_i (pg_step),
        .n_i    (n_q),
        .perm_o (perm_flat),
        .neg_o  (pg_neg),
        .last_o (pg_last)
    );

    // Element a[r][p(r)] for the row currently being folded into the product.
    assign col      = perm_a[r_q];
    assign flat_idx = IW'(r_q) * IW'(MAX_N) + IW'(col);
    assign elem     = mat_q[flat_idx];
    assign mult     = (ACC_W+W)'(prod_q) * (ACC_W+W)'(elem);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        r_d     = r_q;
        bad_d   = bad_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        det_d   = det_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                n_d     = size;
                r_d     = 3'd0;
                prod_d  = '0;
                acc_d   = '0;
                det_d   = '0;
                done_d  = 1'b0;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
                bad_d   = !matdet_size_ok(size, MAX_N);
                state_d = bad_d ? ST_DONE : ST_TERM;
            end
            ST_TERM: begin
                prod_d = (r_q == 3'd0) ? ACC_W'(elem) : mult[ACC_W-1:0];
                if (r_q == n_q - 3'd1) begin
                    r_d     = 3'd0;
                    state_d = ST_STEP;
                end else begin
                    r_d = r_q + 3'd1;
                end
            end
            ST_STEP: begin
                acc_d   = pg_neg ? (acc_q - prod_q) : (acc_q + prod_q);
                state_d = pg_last ? ST_DONE : ST_TERM;
            end
            ST_DONE: begin
                if (start) begin
                    done_d = 1'b1;
                    det_d  = acc_q;
                    ovf_d  = (acc_q > RES_MAX) || (acc_q < RES_MIN);
                    err_d  = bad_q;
                end else begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping start mid-computation discards the operation entirely.
        if (!start && ((state_q == ST_LOAD) || (state_q == ST_TERM) || (state_q == ST_STEP))) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            det_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= 3'd0;
            r_q     <= 3'd0;
            bad_q   <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            det_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            r_q     <= r_d;
            bad_q   <= bad_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            det_q   <= det_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign done        = done_q;
    assign det_full    = det_q;
    assign determinant = det_q[W-1:0];
    assign overflow    = ovf_q;
    assign err         = err_q;

endmodule

// File: tb/tb_matrix_determ_nxn.sv
// Randomized and directed checks of matrix_determ_nxn against a brute-force
// permutation-tuple determinant model.
module tb_matrix_determ_nxn;

    localparam int W     = 8;
    localparam int MAX_N = 5;
    localparam int ACC_W = MAX_N*W + 7;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [2:0]               size;
    logic [MAX_N*MAX_N*W-1:0] matrix;
    logic                     done;
    logic [W-1:0]             determinant;
    logic [ACC_W-1:0]         det_full;
    logic                     overflow;
    logic                     err;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint a_m [MAX_N][MAX_N];

    always #5 clk = ~clk;

    matrix_determ_nxn #(.W(W), .MAX_N(MAX_N), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .size        (size),
        .matrix      (matrix),
        .done        (done),
        .determinant (determinant),
        .det_full    (det_full),
        .overflow    (overflow),
        .err         (err)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint det_now();
        return longint'($signed(det_full));
    endfunction

    // Sum over every n-tuple of distinct columns; parity from inversion count.
    function automatic longint ref_det(input int n);
        longint total;
        longint term;
        int     tup [MAX_N];
        int     lim;
        int     v;
        int     inv;
        bit     dup;
        total = 0;
        lim   = 1;
        for (int k = 0; k < n; k++) lim = lim * n;
        for (int t = 0; t < lim; t++) begin
            v   = t;
            dup = 1'b0;
            inv = 0;
            for (int r = 0; r < n; r++) begin
                tup[r] = v % n;
                v      = v / n;
            end
            for (int r = 0; r < n; r++)
                for (int s = r + 1; s < n; s++) begin
                    if (tup[r] == tup[s]) dup = 1'b1;
                    if (tup[r] > tup[s]) inv++;
                end
            if (!dup) begin
                term = 1;
                for (int r = 0; r < n; r++) term = term * a_m[r][tup[r]];
                total = (inv % 2 == 1) ? total - term : total + term;
            end
        end
        return total;
    endfunction

    function automatic int fact(input int n);
        int f = 1;
        for (int k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    task automatic fill_rand(input bit full);
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++)
                a_m[r][c] = full ? longint'($signed(W'($urandom)))
                                 : longint'($urandom_range(6)) - 3;
    endtask

    task automatic pack_matrix();
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++)
                matrix[(r*MAX_N + c)*W +: W] = W'(a_m[r][c]);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < MAX_N*MAX_N; i++) matrix[i*W +: W] = W'($urandom);
        size = 3'($urandom);
    endtask

    task automatic run_op(input string tag, input int sz, input bit rst_in_done);
        longint exp_det;
        longint exp_ovf;
        int     exp_lat;
        int     cnt;
        bit     legal;
        legal   = (sz >= 1) && (sz <= MAX_N);
        exp_det = legal ? ref_det(sz) : 0;
        exp_lat = legal ? fact(sz)*(sz + 1) + 2 : 2;
        exp_ovf = (exp_det > 127 || exp_det < -128) ? 1 : 0;
        pack_matrix();
        size  = 3'(sz);
        start = 1'b1;
        @(posedge clk);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 3) scramble_inputs();
        end while (!done && cnt < 2000);
        check_val({tag, "_lat"}, cnt, exp_lat);
        check_val({tag, "_det"}, det_now(), exp_det);
        check_val({tag, "_low"}, longint'(determinant), exp_det & 64'hFF);
        check_val({tag, "_ovf"}, longint'(overflow), exp_ovf);
        check_val({tag, "_err"}, longint'(err), legal ? 0 : 1);
        repeat (2) begin @(posedge clk); #1; end
        check_val({tag, "_hold"}, det_now() + (done ? 0 : 1000), exp_det);
        if (rst_in_done) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check_val({tag, "_rst_det"}, det_now(), 0);
            check_val({tag, "_rst_done"}, longint'(done), 0);
            rst   = 1'b0;
            start = 1'b0;
        end else begin
            start = 1'b0;
            @(posedge clk); #1;
            check_val({tag, "_drop"}, longint'(done), 0);
        end
        @(posedge clk); #1;
        $display("op %s n=%0d det=%0d lat=%0d", tag, sz, det_now(), cnt);
    endtask

    task automatic run_interrupt(input string tag, input int at_edge, input bit use_rst);
        int cnt;
        int rose;
        rose = 0;
        fill_rand(1'b1);
        pack_matrix();
        size  = use_rst ? 3'd4 : 3'd5;
        start = 1'b1;
        @(posedge clk);
        cnt = 0;
        while (cnt < at_edge) begin
            @(posedge clk); #1;
            cnt++;
            if (done) rose++;
        end
        if (use_rst) rst = 1'b1;
        else         start = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_done"}, longint'(done), 0);
        check_val({tag, "_det"}, det_now(), 0);
        check_val({tag, "_flags"}, longint'({overflow, err}), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) rose++;
        end
        check_val({tag, "_never"}, rose, 0);
        $display("op %s stopped at edge %0d", tag, at_edge);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        size   = 3'd0;
        matrix = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_done", longint'(done), 0);
        check_val("rst_det", det_now(), 0);
        check_val("rst_flags", longint'({overflow, err, determinant}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill_rand(1'b1);
        a_m[0][0] = 3; a_m[0][1] = 8; a_m[1][0] = 4; a_m[1][1] = 6;
        run_op("ex2x2", 2, 1'b0);

        fill_rand(1'b1);
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) a_m[r][c] = (r == c) ? 2 : 0;
        run_op("diag3", 3, 1'b0);

        for (int r = 0; r < MAX_N; r++) for (int c = 0; c < MAX_N; c++) a_m[r][c] = (r == c) ? 1 : 0;
        run_op("ident5", 5, 1'b0);

        fill_rand(1'b1);
        for (int c = 0; c < MAX_N; c++) a_m[2][c] = a_m[0][c];
        run_op("eqrows4", 4, 1'b0);

        fill_rand(1'b1);
        a_m[0][0] = 127; a_m[0][1] = 0; a_m[1][0] = 0; a_m[1][1] = 127;
        run_op("ovf2", 2, 1'b1);

        fill_rand(1'b1);
        run_op("bad7", 7, 1'b0);
        run_op("bad0", 0, 1'b0);
        run_op("one", 1, 1'b0);

        run_interrupt("abort5", 100, 1'b0);
        fill_rand(1'b0);
        run_op("after_abort", 3, 1'b0);

        run_interrupt("rst4", 50, 1'b1);
        fill_rand(1'b0);
        run_op("after_rst", 4, 1'b0);

        for (int k = 0; k < 12; k++) begin
            fill_rand(k[0]);
            run_op($sformatf("rnd%0d", k), int'($urandom_range(1, MAX_N)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/matrix_determ_nxn.md
MATRIX_DETERM_NXN -- requirements
Module: matrix_determ_nxn

Interface
REQ-001 Parameter W, default 8: signed two's-complement element and result width; legal range 4..16.
REQ-002 Parameter MAX_N, default 5: largest supported matrix order; legal range 2..5.
REQ-003 Parameter ACC_W, default MAX_N*W+7: internal accumulator and det_full width.
REQ-004 clk  input  1  system clock; the block SHALL use one clock domain, clocked on rising edges only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level request; held high for the whole operation.
REQ-007 size  input  3  matrix order N for this operation; runtime-selectable from 1 to MAX_N.
REQ-008 matrix  input  MAX_N*MAX_N*W  element (r,c) at bits [(r*MAX_N+c)*W +: W]; unused rows and columns are ignored.
REQ-009 done  output  1  result valid.
REQ-010 determinant  output  W  low W bits of det_full.
REQ-011 det_full  output  ACC_W  exact signed determinant.
REQ-012 overflow  output  1  exact result is outside the signed W-bit range.
REQ-013 err  output  1  illegal size.

Function
REQ-014 The block SHALL compute det = sum over all permutations p of sign(p)*prod_r a[r][p(r)], with exact ACC_W-bit arithmetic.
REQ-015 It SHALL enumerate permutations with Heap's algorithm: one transposition per step, sign toggled on every step, identity first with sign +1.
REQ-016 The state machine SHALL have the states IDLE, LOAD, TERM, STEP and DONE.
REQ-017 IDLE->LOAD SHALL occur on an edge that samples start=1.
REQ-018 In LOAD the block SHALL latch matrix and size, set perm to identity, sign to +1 and acc to 0, and clear all Heap counters.
REQ-019 In TERM the block SHALL run N cycles, one multiply per cycle: prod<=a[0][p(0)] on the first cycle, then prod<=prod*a[r][p(r)].
REQ-020 STEP SHALL take 1 cycle: acc<=acc+/-prod; find the smallest i>=1 with c[i]<i; swap, increment c[i] and clear c[j] for j<i; go to TERM, or go to DONE when no such i<N exists.
REQ-021 Latency: done SHALL rise N!*(N+1)+2 edges after the edge that first sampled start=1 (N=2: 8; N=3: 26; N=5: 722).
REQ-022 In DONE, done, determinant, det_full, overflow and err SHALL be held stable while start=1.
REQ-023 DONE->IDLE SHALL occur on the first edge that samples start=0, with done cleared on that edge.
REQ-024 If start=0 is sampled in LOAD, TERM or STEP, the block SHALL abort to IDLE on the next edge, with done=0 and the results cleared.
REQ-025 Changes on matrix or size after LOAD SHALL NOT affect the result.
REQ-026 size=0 or size>MAX_N SHALL go LOAD->DONE with err=1, det_full=0 and overflow=0, so done rises after 2 edges.
REQ-027 size=1 SHALL yield a[0][0] from a single term (latency 4).
REQ-028 overflow SHALL equal (det_full > 2^(W-1)-1) or (det_full < -2^(W-1)), evaluated in DONE.

Reset
REQ-029 rst=1 SHALL force IDLE and clear done, determinant, det_full, overflow, err, acc, prod, perm, sign and all counters on the next edge, in every state including mid-operation.
REQ-030 rst SHALL take priority over start.

Structure
REQ-031 Package matdet_pkg SHALL hold the state enum, the default MAX_N and W, and the size-legality constant.
REQ-032 Sub-module matdet_perm_gen SHALL hold the Heap permutation state (perm array, c counters, sign, last flag) and advance on a step strobe.
REQ-033 The arithmetic SHALL use a single multiplier of W x ACC_W, and no combinational path SHALL go from start to done.

Verification
REQ-034 W=8, N=2, [[3,8],[4,6]] -> det_full=-14, determinant=0xF2, overflow=0, done at edge 8.
REQ-035 N=3, diagonal of 2s -> det=8; N=5 identity -> det=1, done at edge 722; N=4 with rows 0 and 2 equal -> det=0.
REQ-036 W=8, N=2, [[127,0],[0,127]] -> det_full=16129, determinant=0x01, overflow=1.
REQ-037 N=5 with start dropped at edge 100 -> done never rises and the block is in IDLE at edge 101; a following request computes a fresh correct result.
REQ-038 rst pulsed at edge 50 of an N=4 operation -> all outputs 0 next edge; size=7 with MAX_N=5 -> err=1, det_full=0, done at edge 2.
